// File: rtl/seq_frame_scanner_if.sv
// Word-in / count-out handshake bundle for seq_frame_scanner.
// The slave modport is the scanner; the master modport is the producer/consumer side.
interface seq_frame_scanner_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_keep;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_hit;

  modport slave (
    input  in_valid, in_data, in_keep, out_ready,
    output in_ready, busy, out_valid, out_count, out_hit
  );

  modport master (
    output in_valid, in_data, in_keep, out_ready,
    input  in_ready, busy, out_valid, out_count, out_hit
  );
endinterface

// File: rtl/seq_frame_scanner.sv
// Serialises each accepted word MSB-first through an overlapping pattern matcher
// and returns the saturated per-word match count on a valid/ready result port.
module seq_frame_scanner #(
  parameter int                 WORD_W  = 16,
  parameter int                 PAT_LEN = 7,
  parameter logic [PAT_LEN-1:0] PAT     = 7'b0011010,
  parameter int                 CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_frame_scanner_if.slave   bus
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_word;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_count;
  logic [PAT_LEN-2:0]  r_hist;
  logic [FILL_W-1:0]   r_fill;

  logic                w_accept;
  logic                w_bit;
  logic [PAT_LEN-1:0]  w_win;
  logic                w_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_bit    = r_word[r_idx];
  assign w_win    = {r_hist, w_bit};
  // A window is only trusted once PAT_LEN-1 real bits sit in the history.
  assign w_match  = (r_fill >= FILL_MAX) && (w_win == PAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid)   w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_idx == '0)    w_state_nxt = S_REPORT;
      S_REPORT: if (bus.out_ready)  w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.busy      = (r_state != S_IDLE);
    bus.out_valid = (r_state == S_REPORT);
    bus.out_count = (r_state == S_REPORT) ? r_count : '0;
    bus.out_hit   = (r_state == S_REPORT) && (r_count != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word  <= bus.in_data;
            r_idx   <= IDX_W'(WORD_W - 1);
            r_count <= '0;
            if (!bus.in_keep) begin
              r_hist <= '0;
              r_fill <= '0;
            end
          end
        end
        S_SHIFT: begin
          if (w_match) r_count <= sat_inc(r_count);
          r_hist <= w_win[PAT_LEN-2:0];
          if (r_fill != FILL_MAX) r_fill <= r_fill + FILL_W'(1);
          r_idx  <= r_idx - IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_scanner.sv
// Directed bench for seq_frame_scanner: a CNT_W=5 instance and a CNT_W=1 instance
// driven in lockstep with hand-computed expected counts and latencies.
module tb_seq_frame_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_frame_scanner_if #(.WORD_W(16), .CNT_W(5)) ifc ();
  seq_frame_scanner_if #(.WORD_W(16), .CNT_W(1)) if1 ();

  seq_frame_scanner #(.WORD_W(16), .PAT_LEN(7), .PAT(7'b0011010), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  seq_frame_scanner #(.WORD_W(16), .PAT_LEN(7), .PAT(7'b0011010), .CNT_W(1)) dut_sat (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  assign if1.in_valid  = ifc.in_valid;
  assign if1.in_data   = ifc.in_data;
  assign if1.in_keep   = ifc.in_keep;
  assign if1.out_ready = ifc.out_ready;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Call just after a negedge with the DUT idle; returns just after the negedge
  // of the cycle following the result handshake (out_ready held high).
  task automatic run_word(input logic [15:0] d, input logic k, output int lat,
                          output logic [4:0] cnt, output logic hit,
                          output logic cnt1, output logic hit1);
    ifc.in_valid  = 1'b1;
    ifc.in_data   = d;
    ifc.in_keep   = k;
    ifc.out_ready = 1'b1;
    chk("acc_rdy", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    lat = 1;
    while (!ifc.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    cnt  = ifc.out_count;
    hit  = ifc.out_hit;
    cnt1 = if1.out_count;
    hit1 = if1.out_hit;
    @(negedge clk);
  endtask

  int         lat;
  logic [4:0] cnt;
  logic       hit, cnt1, hit1;

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_keep   = 1'b0;
    ifc.out_ready = 1'b0;
    rst           = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(ifc.busy),      32'd0);
    chk("rst_oval",  32'(ifc.out_valid), 32'd0);
    chk("rst_cnt",   32'(ifc.out_count), 32'd0);
    chk("rst_hit",   32'(ifc.out_hit),   32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rdy",   32'(ifc.in_ready),  32'd1);

    // single match, latency and next-accept timing
    run_word(16'h1A00, 1'b0, lat, cnt, hit, cnt1, hit1);
    chk("t1_lat",  32'(lat), 32'd17);
    chk("t1_cnt",  32'(cnt), 32'd1);
    chk("t1_hit",  32'(hit), 32'd1);
    chk("t1_rdy",  32'(ifc.in_ready), 32'd1);
    chk("t1_oval", 32'(ifc.out_valid), 32'd0);

    // overlapping matches; CNT_W=1 instance saturates
    run_word(16'h34D0, 1'b0, lat, cnt, hit, cnt1, hit1);
    chk("t2_lat",  32'(lat),  32'd17);
    chk("t2_cnt",  32'(cnt),  32'd2);
    chk("t2_hit",  32'(hit),  32'd1);
    chk("t5_cnt1", 32'(cnt1), 32'd1);
    chk("t5_hit1", 32'(hit1), 32'd1);

    // pattern straddling a word boundary, with and without carry-over
    run_word(16'h0003, 1'b0, lat, cnt, hit, cnt1, hit1);
    chk("t3a_cnt", 32'(cnt), 32'd0);
    chk("t3a_hit", 32'(hit), 32'd0);
    run_word(16'h4000, 1'b1, lat, cnt, hit, cnt1, hit1);
    chk("t3b_cnt", 32'(cnt), 32'd1);
    chk("t3b_hit", 32'(hit), 32'd1);
    run_word(16'h0003, 1'b0, lat, cnt, hit, cnt1, hit1);
    chk("t3c_cnt", 32'(cnt), 32'd0);
    run_word(16'h4000, 1'b0, lat, cnt, hit, cnt1, hit1);
    chk("t3d_cnt", 32'(cnt), 32'd0);

    // backpressure with a stray in_valid pulse during REPORT
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'h34D0;
    ifc.in_keep   = 1'b0;
    ifc.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    lat = 1;
    while (!ifc.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_lat", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      chk("t4_oval", 32'(ifc.out_valid), 32'd1);
      chk("t4_cnt",  32'(ifc.out_count), 32'd2);
      chk("t4_rdy",  32'(ifc.in_ready),  32'd0);
      chk("t4_busy", 32'(ifc.busy),      32'd1);
      if (i == 2) begin
        ifc.in_valid = 1'b1;
        ifc.in_data  = 16'h1A00;
      end
      if (i == 3) ifc.in_valid = 1'b0;
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rel_oval", 32'(ifc.out_valid), 32'd0);
    chk("t4_rel_rdy",  32'(ifc.in_ready),  32'd1);
    chk("t4_rel_cnt",  32'(ifc.out_count), 32'd0);
    chk("t4_rel_busy", 32'(ifc.busy),      32'd0);

    // reset mid-SHIFT aborts the word and clears history
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'h1A00;
    ifc.in_keep  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t6_pre_busy", 32'(ifc.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(ifc.busy),      32'd0);
    chk("t6_oval", 32'(ifc.out_valid), 32'd0);
    chk("t6_cnt",  32'(ifc.out_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rdy", 32'(ifc.in_ready), 32'd1);
    repeat (20) @(negedge clk);
    chk("t6_nores", 32'(ifc.out_valid), 32'd0);
    run_word(16'h4000, 1'b1, lat, cnt, hit, cnt1, hit1);
    chk("t6_lat", 32'(lat), 32'd17);
    chk("t6_cnt_after", 32'(cnt), 32'd0);
    chk("t6_hit_after", 32'(hit), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
